// File: rtl/nthband_predictor_pkg.sv
// nthband_predictor_pkg: FSM state type and datapath width helpers
package nthband_predictor_pkg;
  typedef enum logic {LOAD, RUN} state_t;
  function automatic int diff_w(input int dw);
    return dw + 1;
  endfunction
  function automatic int prod_w(input int dw, input int aw);
    return dw + aw + 2;
  endfunction
  function automatic int out_w(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/nthband_pipe_stage.sv
// nthband_pipe_stage: generic valid/ready pipeline register
module nthband_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  // accept a new word whenever the register is empty or being drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/nthband_predictor_pipelined.sv
// nthband_predictor_pipelined: per-block alpha-scaled band predictor, 3-stage pipeline; saturating output with NTHBAND_PREDICTOR_CLAMP_EN
module nthband_predictor_pipelined
  import nthband_predictor_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int ALPHA_WIDTH        = 10,
  parameter int ALPHA_FRAC         = 9,
  parameter int MAX_BLOCK_SIZE_LOG = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(MAX_BLOCK_SIZE_LOG+1)-1:0] cfg_block_size_log,
  input  logic                                   alpha_valid,
  output logic                                   alpha_ready,
  input  logic [ALPHA_WIDTH-1:0]                 alpha_data,
  input  logic                                   xmean_valid,
  output logic                                   xmean_ready,
  input  logic [DATA_WIDTH-1:0]                  xmean_data,
  input  logic                                   xhatmean_valid,
  output logic                                   xhatmean_ready,
  input  logic [DATA_WIDTH-1:0]                  xhatmean_data,
  input  logic                                   xhat_valid,
  output logic                                   xhat_ready,
  input  logic [DATA_WIDTH-1:0]                  xhat_data,
  output logic                                   prediction_valid,
  input  logic                                   prediction_ready,
  output logic [DATA_WIDTH:0]                    prediction_data,
  output logic                                   prediction_last
);
  localparam int DDW = diff_w(DATA_WIDTH);
  localparam int PW  = prod_w(DATA_WIDTH, ALPHA_WIDTH);
  localparam int OW  = out_w(DATA_WIDTH);
  localparam int BW  = $clog2(MAX_BLOCK_SIZE_LOG+1);
  localparam int CW  = (MAX_BLOCK_SIZE_LOG > 0) ? MAX_BLOCK_SIZE_LOG : 1;
  localparam int W1  = DDW + ALPHA_WIDTH + DATA_WIDTH + 1;
  localparam int W2  = PW + DATA_WIDTH + 1;
  localparam int W3  = OW + 1;
  localparam logic signed [PW-1:0] RND = PW'((2**ALPHA_FRAC) / 2);
  localparam logic [CW:0] ONE = 1;
  state_t                  state, state_nx;
  logic [CW-1:0]           cnt;
  logic [ALPHA_WIDTH-1:0]  alpha_r;
  logic [DATA_WIDTH-1:0]   xmean_r, xhatmean_r;
  logic [BW-1:0]           bsl_r;
  logic                    load_fire, xhat_fire, is_last, s1_in_ready;
  logic [CW:0]             cnt_max;
  logic signed [DDW-1:0]   s1_d, s1_q_d;
  logic [ALPHA_WIDTH-1:0]  s1_q_alpha;
  logic [DATA_WIDTH-1:0]   s1_q_xmean, s2_q_xmean;
  logic                    s1_q_last, s2_q_last;
  logic                    s1_valid, s2_valid, s2_in_ready, s3_in_ready;
  logic [W1-1:0]           s1_out;
  logic [W2-1:0]           s2_out;
  logic [W3-1:0]           s3_out;
  logic signed [PW-1:0]    s2_p, s2_q_p, sh;
  logic [OW-1:0]           res;
  assign load_fire      = rst && state == LOAD && alpha_valid && xmean_valid && xhatmean_valid;
  assign alpha_ready    = load_fire;
  assign xmean_ready    = load_fire;
  assign xhatmean_ready = load_fire;
  assign xhat_ready     = state == RUN && s1_in_ready;
  assign xhat_fire      = xhat_valid && xhat_ready;
  assign cnt_max        = (ONE << bsl_r) - ONE;
  assign is_last        = {1'b0, cnt} == cnt_max;
  // next state: LOAD leaves on the joint parameter transfer, RUN leaves after the tagged last sample
  always_comb begin
    state_nx = (state == LOAD) ? (load_fire ? RUN : LOAD) : ((xhat_fire && is_last) ? LOAD : RUN);
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end
  // per-block parameter latch and sample counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      alpha_r    <= '0;
      xmean_r    <= '0;
      xhatmean_r <= '0;
      bsl_r      <= '0;
    end else if (load_fire) begin
      cnt        <= '0;
      alpha_r    <= alpha_data;
      xmean_r    <= xmean_data;
      xhatmean_r <= xhatmean_data;
      bsl_r      <= cfg_block_size_log;
    end else if (xhat_fire) begin
      cnt <= cnt + CW'(1);
    end
  end
  assign s1_d = {1'b0, xhat_data} - {1'b0, xhatmean_r};
  nthband_pipe_stage #(.WIDTH(W1)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(state == RUN && xhat_valid), .in_ready(s1_in_ready),
    .in_data({s1_d, alpha_r, xmean_r, is_last}),
    .out_valid(s1_valid), .out_ready(s2_in_ready), .out_data(s1_out)
  );
  assign {s1_q_d, s1_q_alpha, s1_q_xmean, s1_q_last} = s1_out;
  assign s2_p = PW'(s1_q_d) * PW'($signed({1'b0, s1_q_alpha}));
  nthband_pipe_stage #(.WIDTH(W2)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(s1_valid), .in_ready(s2_in_ready),
    .in_data({s2_p, s1_q_xmean, s1_q_last}),
    .out_valid(s2_valid), .out_ready(s3_in_ready), .out_data(s2_out)
  );
  assign {s2_q_p, s2_q_xmean, s2_q_last} = s2_out;
  assign sh = (s2_q_p + RND) >>> ALPHA_FRAC;
`ifdef NTHBAND_PREDICTOR_CLAMP_EN
  localparam logic signed [PW:0] MAXV = (PW+1)'((64'd1 << DATA_WIDTH) - 64'd1);
  logic signed [PW:0] sum;
  assign sum = (PW+1)'(sh) + (PW+1)'({1'b0, s2_q_xmean});
  assign res = (sum < 0) ? '0 : ((sum > MAXV) ? {1'b0, {DATA_WIDTH{1'b1}}} : sum[OW-1:0]);
`else
  assign res = OW'(sh) + {1'b0, s2_q_xmean};
`endif
  nthband_pipe_stage #(.WIDTH(W3)) u_s3 (
    .clk(clk), .rst(rst),
    .in_valid(s2_valid), .in_ready(s3_in_ready),
    .in_data({res, s2_q_last}),
    .out_valid(prediction_valid), .out_ready(prediction_ready), .out_data(s3_out)
  );
  assign {prediction_data, prediction_last} = s3_out;
endmodule

// File: tb/tb_nthband_predictor_pipelined.sv
// tb_nthband_predictor_pipelined: randomized scenario bench against an arithmetic reference model
module tb_nthband_predictor_pipelined;
  localparam int AF = 9;
  logic        clk = 0, rst = 0;
  logic [3:0]  cfg_block_size_log = 0;
  logic        alpha_valid = 0, xmean_valid = 0, xhatmean_valid = 0, xhat_valid = 0;
  logic        alpha_ready, xmean_ready, xhatmean_ready, xhat_ready;
  logic [9:0]  alpha_data = 0;
  logic [15:0] xmean_data = 0, xhatmean_data = 0, xhat_data = 0;
  logic        prediction_valid, prediction_last;
  logic        prediction_ready = 1;
  logic [16:0] prediction_data;
  int vectors = 0, miscompares = 0, cyc = 0;
  int first_out_cyc = -1, last_in_cyc = 0;
  bit stall_en = 0;
  logic [16:0] exp_d[$], obs_d[$];
  bit exp_l[$], obs_l[$];
  int smp[$];

  nthband_predictor_pipelined dut (
    .clk(clk), .rst(rst), .cfg_block_size_log(cfg_block_size_log),
    .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha_data(alpha_data),
    .xmean_valid(xmean_valid), .xmean_ready(xmean_ready), .xmean_data(xmean_data),
    .xhatmean_valid(xhatmean_valid), .xhatmean_ready(xhatmean_ready), .xhatmean_data(xhatmean_data),
    .xhat_valid(xhat_valid), .xhat_ready(xhat_ready), .xhat_data(xhat_data),
    .prediction_valid(prediction_valid), .prediction_ready(prediction_ready),
    .prediction_data(prediction_data), .prediction_last(prediction_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst && prediction_valid && prediction_ready) begin
      obs_d.push_back(prediction_data);
      obs_l.push_back(prediction_last);
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
  initial forever begin
    @(posedge clk);
    #1 prediction_ready = stall_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  function automatic logic [16:0] model(input int a, input int xm, input int xhm, input int x);
    longint p, s;
    p = longint'(x - xhm) * longint'(a);
    s = longint'(xm) + ((p + longint'((1 << AF) / 2)) >>> AF);
`ifdef NTHBAND_PREDICTOR_CLAMP_EN
    s = (s < 0) ? 0 : ((s > 65535) ? 65535 : s);
`endif
    return s[16:0];
  endfunction

  task automatic clear_q();
    exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
    first_out_cyc = -1;
  endtask

  task automatic load_params(input int a, input int xm, input int xhm, input int bsl, output bit ok);
    alpha_data = 10'(a); xmean_data = 16'(xm); xhatmean_data = 16'(xhm);
    cfg_block_size_log = 4'(bsl);
    alpha_valid = 1; xmean_valid = 1; xhatmean_valid = 1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (alpha_ready && xmean_ready && xhatmean_ready) ok = 1;
      @(posedge clk); #1;
    end
    alpha_valid = 0; xmean_valid = 0; xhatmean_valid = 0;
    cfg_block_size_log = 4'($urandom_range(0, 15));
  endtask

  task automatic send_sample(input int x, output bit ok);
    xhat_valid = 1; xhat_data = 16'(x);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (xhat_ready) begin ok = 1; last_in_cyc = cyc; end
      @(posedge clk); #1;
    end
    xhat_valid = 0;
  endtask

  task automatic run_block(input int a, input int xm, input int xhm, input int bsl, output bit ok);
    bit o;
    load_params(a, xm, xhm, bsl, o);
    ok = o;
    for (int i = 0; i < smp.size(); i++) begin
      exp_d.push_back(model(a, xm, xhm, smp[i]));
      exp_l.push_back(i == smp.size() - 1);
      send_sample(smp[i], o);
      if (!o) ok = 0;
    end
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #2;
      if (obs_d.size() >= exp_d.size()) ok = 1;
    end
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 0;
    alpha_valid = 1; xmean_valid = 1; xhatmean_valid = 1; xhat_valid = 1;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({prediction_valid, prediction_data, prediction_last, alpha_ready, xmean_ready, xhatmean_ready, xhat_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d last=%0b readies=%b%b%b%b, expected all 0",
               prediction_valid, prediction_data, prediction_last, alpha_ready, xmean_ready, xhatmean_ready, xhat_ready);
    end
    alpha_valid = 0; xmean_valid = 0; xhatmean_valid = 0; xhat_valid = 0;
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_basic();
    int ref_v[4] = '{1000, 1050, 950, 1001};
    bit ok;
    int t_in;
    clear_q();
    smp = '{500, 600, 400, 501};
    run_block(256, 1000, 500, 2, ok);
    drain(ok);
    vectors++;
    if (!ok || obs_d.size() != 4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d outputs, expected 4", obs_d.size());
    end
    for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_d[i] !== 17'(ref_v[i]) || obs_l[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL basic[%0d]: got %0d last=%0b, expected %0d last=%0b", i, obs_d[i], obs_l[i], ref_v[i], i == 3);
      end
    end
    clear_q();
    smp = '{$urandom_range(0, 65535)};
    run_block(300, 1234, 2000, 0, ok);
    t_in = last_in_cyc;
    drain(ok);
    vectors++;
    if (first_out_cyc - t_in != 3) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, expected 3", first_out_cyc - t_in);
    end
    vectors++;
    if (obs_d.size() != 1 || obs_d[0] !== exp_d[0] || obs_l[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_block: got %0d (n=%0d), expected %0d", obs_d.size() > 0 ? obs_d[0] : 0, obs_d.size(), exp_d[0]);
    end
  endtask

  task automatic test_alpha_zero();
    bit ok;
    int xm, t0, nl;
    clear_q();
    xm = $urandom_range(0, 65535);
    smp.delete();
    for (int i = 0; i < 256; i++) smp.push_back($urandom_range(0, 65535));
    load_params(0, xm, $urandom_range(0, 65535), 8, ok);
    for (int i = 0; i < 256; i++) begin
      send_sample(smp[i], ok);
      if (i == 0) t0 = last_in_cyc;
    end
    vectors++;
    if (last_in_cyc - t0 != 255) begin
      miscompares++;
      $display("FAIL throughput: got %0d cycles for 256 samples, expected 255", last_in_cyc - t0);
    end
    drain(ok);
    vectors++;
    if (!ok || obs_d.size() != 256) begin
      miscompares++;
      $display("FAIL alpha0_count: got %0d outputs, expected 256", obs_d.size());
    end
    nl = 0;
    for (int i = 0; i < obs_d.size(); i++) begin
      nl += obs_l[i];
      vectors++;
      if (obs_d[i] !== 17'(xm)) begin
        miscompares++;
        $display("FAIL alpha0[%0d]: got %0d, expected %0d", i, obs_d[i], xm);
      end
    end
    vectors++;
    if (nl != 1 || obs_l.size() != 256 || obs_l[255] !== 1'b1) begin
      miscompares++;
      $display("FAIL alpha0_last: got %0d last flags, expected exactly 1 on sample 255", nl);
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int want;
`ifdef NTHBAND_PREDICTOR_CLAMP_EN
    want = 65535;
`else
    want = 65635;
`endif
    clear_q();
    smp = '{1100, 900};
    run_block(512, 65535, 1000, 1, ok);
    drain(ok);
    vectors++;
    if (obs_d.size() != 2 || obs_d[0] !== 17'(want) || obs_d[1] !== exp_d[1]) begin
      miscompares++;
      $display("FAIL clamp: got %0d,%0d (n=%0d), expected %0d,%0d",
               obs_d.size() > 0 ? obs_d[0] : 0, obs_d.size() > 1 ? obs_d[1] : 0, obs_d.size(), want, exp_d[1]);
    end
  endtask

  task automatic test_stall();
    bit ok, all_ok;
    int bsl;
    clear_q();
    stall_en = 1;
    all_ok = 1;
    for (int b = 0; b < 3; b++) begin
      bsl = $urandom_range(0, 4);
      smp.delete();
      for (int i = 0; i < (1 << bsl); i++) smp.push_back($urandom_range(0, 65535));
      run_block($urandom_range(0, 1023), $urandom_range(0, 65535), $urandom_range(0, 65535), bsl, ok);
      if (!ok) all_ok = 0;
    end
    drain(ok);
    stall_en = 0;
    vectors++;
    if (!all_ok || !ok || obs_d.size() != exp_d.size()) begin
      miscompares++;
      $display("FAIL stall_count: got %0d outputs, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %0d last=%0b, expected %0d last=%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_partial_params();
    bit ok;
    clear_q();
    for (int p = 0; p < 3; p++) begin
      alpha_valid = (p != 0); xmean_valid = (p != 1); xhatmean_valid = (p != 2); xhat_valid = 1;
      repeat (4) begin
        @(negedge clk);
        vectors++;
        if (alpha_ready || xmean_ready || xhatmean_ready || xhat_ready) begin
          miscompares++;
          $display("FAIL partial_params[%0d]: got readies=%b%b%b%b, expected 0000", p, alpha_ready, xmean_ready, xhatmean_ready, xhat_ready);
        end
      end
      @(posedge clk); #1;
    end
    xhat_valid = 0;
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back($urandom_range(0, 65535));
    run_block($urandom_range(0, 1023), $urandom_range(0, 65535), $urandom_range(0, 65535), 3, ok);
    drain(ok);
    vectors++;
    if (!ok || obs_d.size() != 8) begin
      miscompares++;
      $display("FAIL partial_count: got %0d outputs, expected 8", obs_d.size());
    end
    for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL partial[%0d]: got %0d last=%0b, expected %0d last=%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_q();
    load_params(700, 20000, 100, 3, ok);
    send_sample(30000, ok);
    send_sample(40000, ok);
    xhat_valid = 1; xhat_data = 16'd50000;
    @(posedge clk);
    #3 rst = 0;
    alpha_valid = 1; xmean_valid = 1; xhatmean_valid = 1;
    #1;
    vectors++;
    if ({prediction_valid, prediction_data, prediction_last, alpha_ready, xmean_ready, xhatmean_ready, xhat_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%0b data=%0d last=%0b readies=%b%b%b%b, expected all 0",
               prediction_valid, prediction_data, prediction_last, alpha_ready, xmean_ready, xhatmean_ready, xhat_ready);
    end
    repeat (3) @(posedge clk);
    alpha_valid = 0; xmean_valid = 0; xhatmean_valid = 0; xhat_valid = 0;
    #1 rst = 1;
    clear_q();
    smp.delete();
    for (int i = 0; i < 4; i++) smp.push_back($urandom_range(0, 65535));
    run_block($urandom_range(0, 1023), $urandom_range(0, 65535), $urandom_range(0, 65535), 2, ok);
    drain(ok);
    vectors++;
    if (!ok || obs_d.size() != 4) begin
      miscompares++;
      $display("FAIL reset_mid_count: got %0d outputs, expected 4", obs_d.size());
    end
    for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got %0d last=%0b, expected %0d last=%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alpha_zero();
    test_clamp();
    test_stall();
    test_partial_params();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
